// File: rtl/cmd_router.sv
// Byte-serial command-frame router: reads the type byte at TYPE_POS and replays each frame on one channel.
// Optional dropped-frame counter enabled by defining CMD_ROUTER_DROP_CNT_EN.
module cmd_router #(
    parameter int                         DATA_W   = 8,
    parameter int                         LEN_W    = 8,
    parameter int                         CH_NUM   = 3,
    parameter int                         TYPE_POS = 1,
    parameter logic [CH_NUM*DATA_W-1:0]   CH_LO    = {8'd9, 8'd6, 8'd1},
    parameter logic [CH_NUM*DATA_W-1:0]   CH_HI    = {8'd255, 8'd8, 8'd5}
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DATA_W-1:0]          i_cmd_data,
    input  logic [LEN_W-1:0]           i_cmd_len,
    input  logic                       i_cmd_last,
    input  logic                       i_cmd_valid,
    input  logic [CH_NUM-1:0]          i_ch_en,
    output logic [CH_NUM*DATA_W-1:0]   o_ch_data,
    output logic [CH_NUM*LEN_W-1:0]    o_ch_len,
    output logic [CH_NUM-1:0]          o_ch_last,
    output logic [CH_NUM-1:0]          o_ch_valid,
    output logic                       o_busy,
    output logic [15:0]                o_drop_cnt
);

    localparam int L     = TYPE_POS + 2;
    localparam int IDX_W = 4;

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_p_data [0:L-1];
    logic [LEN_W-1:0]  r_p_len  [0:L-1];
    logic [L-1:0]      r_p_valid;
    logic [L-1:0]      r_p_last;
    logic [L-1:0]      r_p_first;
    logic [CH_NUM-1:0] r_dec;
    logic [CH_NUM-1:0] r_sel;
    logic [CH_NUM-1:0] w_match;
    logic              w_dec_beat;
    logic              w_first;
    logic              w_load;

    assign w_dec_beat = i_cmd_valid && (r_idx == IDX_W'(TYPE_POS));
    assign w_first    = i_cmd_valid && (r_idx == '0);
    assign w_load     = r_p_valid[L-2] && r_p_first[L-2];

    // Scan from the top down so the lowest matching channel index wins.
    always_comb begin
        w_match = '0;
        for (int c = CH_NUM - 1; c >= 0; c--) begin
            if (i_ch_en[c] &&
                (i_cmd_data >= CH_LO[c*DATA_W +: DATA_W]) &&
                (i_cmd_data <= CH_HI[c*DATA_W +: DATA_W])) begin
                w_match    = '0;
                w_match[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
        end else if (!i_cmd_valid || i_cmd_last) begin
            r_idx <= '0;
        end else if (r_idx != '1) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // NOTE: the delay pipe is reset explicitly because a mid-frame reset must flush it at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < L; s++) begin
                r_p_data[s] <= '0;
                r_p_len[s]  <= '0;
            end
            r_p_valid <= '0;
            r_p_last  <= '0;
            r_p_first <= '0;
        end else begin
            r_p_data[0] <= i_cmd_valid ? i_cmd_data : '0;
            r_p_len[0]  <= i_cmd_valid ? i_cmd_len  : '0;
            for (int s = 1; s < L; s++) begin
                r_p_data[s] <= r_p_data[s-1];
                r_p_len[s]  <= r_p_len[s-1];
            end
            r_p_valid <= {r_p_valid[L-2:0], i_cmd_valid};
            r_p_last  <= {r_p_last[L-2:0],  i_cmd_valid & i_cmd_last};
            r_p_first <= {r_p_first[L-2:0], w_first};
        end
    end

    // r_dec is cleared at each frame start so a short or early-aborted frame selects nothing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dec <= '0;
            r_sel <= '0;
        end else begin
            if (w_dec_beat) begin
                r_dec <= w_match;
            end else if (w_first) begin
                r_dec <= '0;
            end
            if (w_load) begin
                r_sel <= r_dec;
            end else if (!r_p_valid[L-1] || r_p_last[L-1]) begin
                r_sel <= '0;
            end
        end
    end

    always_comb begin
        o_ch_data  = '0;
        o_ch_len   = '0;
        o_ch_last  = '0;
        o_ch_valid = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (r_sel[c] && r_p_valid[L-1]) begin
                o_ch_data[c*DATA_W +: DATA_W] = r_p_data[L-1];
                o_ch_len[c*LEN_W +: LEN_W]    = r_p_len[L-1];
                o_ch_last[c]                  = r_p_last[L-1];
                o_ch_valid[c]                 = 1'b1;
            end
        end
    end

    assign o_busy = i_cmd_valid || (|r_p_valid);

`ifdef CMD_ROUTER_DROP_CNT_EN
    logic        r_nomatch;
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    // r_nomatch keeps an unmatched frame that later aborts from being counted twice.
    assign w_drop = (w_dec_beat && (w_match == '0)) ||
                    (i_cmd_valid && i_cmd_last && (r_idx < IDX_W'(TYPE_POS))) ||
                    (!i_cmd_valid && (r_idx != '0) && !r_nomatch);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_nomatch  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (!i_cmd_valid || i_cmd_last) begin
                r_nomatch <= 1'b0;
            end else if (w_dec_beat) begin
                r_nomatch <= (w_match == '0);
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: doc/cmd_router.md
# cmd_router

Parametrised command-frame router between the host command parser and the functional units: ADC, flash, control and future additions. It accepts byte-serial command frames on a single valid/last bus and reads the type byte at a configurable position in each frame. It matches that byte against per-channel type ranges and replays the whole frame, header included, on exactly one of CH_NUM output channels at fixed latency. Frames that match no channel, are too short, or are aborted are dropped and counted.

## Interface
- DATA_W, 8: frame byte width.
- LEN_W, 8: length field width, passed through unmodified.
- CH_NUM, 3: number of output channels (1..8).
- TYPE_POS, 1: zero-based beat index of the type byte within a frame (0..7).
- CH_LO, {8'd9,8'd6,8'd1}: packed CH_NUM×DATA_W inclusive lower type bound; channel c occupies slice [c*DATA_W +: DATA_W].
- CH_HI, {8'd255,8'd8,8'd5}: packed CH_NUM×DATA_W inclusive upper type bound.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cmd_data  in  DATA_W  frame byte.
- i_cmd_len  in  LEN_W  frame length, forwarded with each beat.
- i_cmd_last  in  1  final beat of frame.
- i_cmd_valid  in  1  beat qualifier; high contiguously for a whole frame.
- i_ch_en  in  CH_NUM  per-channel enable; a disabled channel never matches.
- o_ch_data  out  CH_NUM×DATA_W  per-channel byte, zero when that channel is not valid.
- o_ch_len  out  CH_NUM×LEN_W  per-channel length, zero when not valid.
- o_ch_last  out  CH_NUM  per-channel last.
- o_ch_valid  out  CH_NUM  per-channel valid; at most one bit high.
- o_busy  out  1  a frame is in the pipe, at input or output.
- o_drop_cnt  out  16  dropped-frame counter.

## Operation
- Beat index counter idx: increments on each valid beat. It clears after a beat with last, and clears on any cycle with valid low.
- Delay pipe: TYPE_POS+2 register stages carrying data/len/last/valid.
- Decision: taken when the beat with idx==TYPE_POS is registered. The selected channel is the lowest index c with i_ch_en[c] && CH_LO[c] <= type <= CH_HI[c]. i_ch_en is sampled at that cycle only.
- The result is latched into sel (one-hot, or none) in the same cycle that beat 0 of the frame leaves the pipe.
- Output: o_ch_*[c] = pipe output when sel[c]; otherwise all fields are zero.
- sel clears after the output beat with last, so back-to-back frames (next valid the cycle after last) route independently.
- Drop rules (each increments o_drop_cnt by 1, once per frame):
  - No channel matches. The frame produces no output beats.
  - Short frame: last arrives at idx < TYPE_POS. No output.
  - Abort: valid falls with idx > 0 and no last received.
    - Abort before the decision: no output.
    - Abort after the decision: beats already forwarded remain on the output. sel clears when the invalid slot reaches the pipe output, and no synthetic last is generated.
- Overlapping ranges are legal: the lowest channel index wins.
- Reset mid-frame: the pipe, idx and sel clear immediately. The partial frame is not counted, and the next frame starts from idx 0.

## Timing
- Latency: L = TYPE_POS+2 cycles from input beat to output beat, for every beat, with no bubbles. Throughput is 1 beat/cycle.
- Reset values: all o_ch_* 0, o_busy 0, o_drop_cnt 0.
- o_busy: high from the first valid input beat until the cycle after the last beat leaves the pipe.
- o_drop_cnt: updates one cycle after the drop condition is detected.

## Configuration
- CMD_ROUTER_DROP_CNT_EN defined: o_drop_cnt is a 16-bit counter that saturates at 16'hFFFF.
- CMD_ROUTER_DROP_CNT_EN not defined: counter logic is removed and o_drop_cnt is tied to 0. Dropping and all other behaviour are unchanged.

## Test plan
- Default parameters, i_ch_en=3'b111, frame {55,03,AA,BB} with last on BB. Required: ch0 outputs exactly those 4 beats starting 3 cycles after beat 0 (last on BB); ch1 and ch2 stay 0.
- Frames with type 06, then 09, sent back-to-back with no gap. Required: the first frame appears on ch1 and the second on ch2, with no overlap and no idle cycle between them.
- Type 00 frame. Required: no output on any channel; o_drop_cnt goes 0→1.
- i_ch_en=3'b101, type 07. Required: frame dropped, drop count +1.
- Abort case: valid falls after 3 beats of a type-02 frame. Required: ch0 shows 3 beats with no last; sel clears; the next type-08 frame routes to ch1.
- Short frame: single-beat frame {55} with last. Required: dropped.
- Reset asserted mid-frame. Required: all outputs are 0 next cycle; o_drop_cnt is 0.
- TYPE_POS=0, CH_NUM=4: type byte is beat 0 and latency is 2.
